// File: rtl/game_pkg.sv
// ============================================================================
// Module  : game_pkg
// Purpose : Shared types and constants for the whack-a-box round controller:
//           FSM state encoding, score/box/timer widths, difficulty codes and
//           the saturating / floored score helpers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PICK  = 3'd1,
    ST_ARMED = 3'd2,
    ST_GAP   = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int SCORE_W = 11;
  localparam int BOX_W   = 2;
  localparam int TIMER_W = 6;
  localparam int DIFF_W  = 2;

  localparam logic [SCORE_W-1:0] SCORE_MAX = 11'd2047;

  localparam logic [DIFF_W-1:0] DIFF_1 = 2'd1;
  localparam logic [DIFF_W-1:0] DIFF_2 = 2'd2;
  localparam logic [DIFF_W-1:0] DIFF_3 = 2'd3;

  // score + difficulty, clamped at SCORE_MAX instead of wrapping
  function automatic logic [SCORE_W-1:0] score_add_sat(
    input logic [SCORE_W-1:0] s,
    input logic [DIFF_W-1:0]  d
  );
    logic [SCORE_W:0] sum;
    sum = {1'b0, s} + {{(SCORE_W + 1 - DIFF_W){1'b0}}, d};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[SCORE_W-1:0];
  endfunction

  // score - 1, held at zero
  function automatic logic [SCORE_W-1:0] score_dec_floor(
    input logic [SCORE_W-1:0] s
  );
    return (s == '0) ? '0 : (s - SCORE_W'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_tick_gen.sv
// ============================================================================
// Module  : game_tick_gen
// Purpose : Game-timer prescaler. Counts enabled clk cycles and emits a
//           one-cycle sec_tick_o on the enabled cycle that completes each
//           block of TICKS_PER_SEC cycles. clr_i restarts the count.
// Ports   : clk        in  1  clock
//           reset      in  1  asynchronous, active-high
//           en_i       in  1  count this cycle
//           clr_i      in  1  restart count at zero (wins over en_i)
//           sec_tick_o out 1  one-cycle second strobe
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_tick_gen #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic sec_tick_o
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    sec_tick_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        sec_tick_o = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_round_controller.sv
// ============================================================================
// Module  : game_round_controller
// Purpose : Whack-a-box round sequencer. Starts a game, draws each target from
//           the LFSR (never repeating the previous target), opens a
//           difficulty-dependent hit window, judges one sensor event per
//           round and maintains score, game timer and difficulty.
// Ports   : clk            in  1   clock
//           reset          in  1   asynchronous, active-high
//           start_i        in  1   start pulse (honoured in IDLE/OVER only)
//           lfsr_value_i   in  3   free-running LFSR, low 2 bits pick the box
//           sensor_valid_i in  1   box-struck strobe
//           sensor_box_i   in  2   box struck
//           target_box_o   out 2   current target
//           target_valid_o out 1   hit window open
//           hit_pulse_o    out 1   correct hit judged
//           miss_pulse_o   out 1   wrong box or timeout judged
//           score_o        out 11  running score
//           game_timer_o   out 6   elapsed seconds
//           difficulty_o   out 2   1..3 from elapsed time
//           game_over_o    out 1   game finished
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module game_round_controller
  import game_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int GAME_SECONDS  = 60,
  parameter int WIN1          = 75_000_000,
  parameter int WIN2          = 50_000_000,
  parameter int WIN3          = 25_000_000,
  parameter int GAP_CYC       = 12_500_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [2:0]         lfsr_value_i,
  input  logic               sensor_valid_i,
  input  logic [BOX_W-1:0]   sensor_box_i,
  output logic [BOX_W-1:0]   target_box_o,
  output logic               target_valid_o,
  output logic               hit_pulse_o,
  output logic               miss_pulse_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [TIMER_W-1:0] game_timer_o,
  output logic [DIFF_W-1:0]  difficulty_o,
  output logic               game_over_o
);

  localparam int WIN_MAX_12 = (WIN1 > WIN2) ? WIN1 : WIN2;
  localparam int WIN_MAX    = (WIN_MAX_12 > WIN3) ? WIN_MAX_12 : WIN3;
  localparam int WIN_CW     = $clog2(WIN_MAX + 1);
  localparam int GAP_CW     = $clog2(GAP_CYC + 1);

  localparam logic [GAP_CW-1:0]  GAP_LAST   = GAP_CW'(GAP_CYC - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GAME_SECONDS - 1);
  localparam logic [TIMER_W-1:0] T_LVL2     = TIMER_W'(GAME_SECONDS / 3);
  localparam logic [TIMER_W-1:0] T_LVL3     = TIMER_W'((2 * GAME_SECONDS) / 3);

  state_e               state_q,    state_d;
  logic [SCORE_W-1:0]   score_q,    score_d;
  logic [TIMER_W-1:0]   timer_q,    timer_d;
  logic [BOX_W-1:0]     target_q,   target_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [WIN_CW-1:0]    win_cnt_q,  win_cnt_d;
  logic [GAP_CW-1:0]    gap_cnt_q,  gap_cnt_d;
  logic                 hit_q,      hit_d;
  logic                 miss_q,     miss_d;

  logic                 w_active;
  logic                 w_start_acc;
  logic                 w_sec_tick;
  logic [DIFF_W-1:0]    w_diff;
  logic [WIN_CW-1:0]    w_win_load;
  logic [BOX_W-1:0]     w_cand;
  logic                 w_unused_lfsr_msb;

  assign w_active    = (state_q == ST_PICK) || (state_q == ST_ARMED) ||
                       (state_q == ST_GAP);
  assign w_start_acc = start_i && ((state_q == ST_IDLE) || (state_q == ST_OVER));
  assign w_cand      = lfsr_value_i[1:0];
  assign w_unused_lfsr_msb = lfsr_value_i[2];

  game_tick_gen #(
    .TICKS_PER_SEC (TICKS_PER_SEC)
  ) u_tick (
    .clk        (clk),
    .reset      (reset),
    .en_i       (w_active),
    .clr_i      (w_start_acc),
    .sec_tick_o (w_sec_tick)
  );

  // Difficulty follows elapsed time directly; the window length is only
  // captured when a round is armed, so a level change never stretches or
  // shortens a window already in progress.
  always_comb begin
    w_diff = DIFF_3;
    if (timer_q < T_LVL2) begin
      w_diff = DIFF_1;
    end else if (timer_q < T_LVL3) begin
      w_diff = DIFF_2;
    end
  end

  always_comb begin
    case (w_diff)
      DIFF_1:  w_win_load = WIN_CW'(WIN1 - 1);
      DIFF_2:  w_win_load = WIN_CW'(WIN2 - 1);
      default: w_win_load = WIN_CW'(WIN3 - 1);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    timer_d    = timer_q;
    target_d   = target_q;
    prev_vld_d = prev_vld_q;
    win_cnt_d  = win_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    hit_d      = 1'b0;
    miss_d     = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_i) begin
          score_d    = '0;
          timer_d    = '0;
          prev_vld_d = 1'b0;
          state_d    = ST_PICK;
        end
      end

      ST_PICK: begin
        // A repeat of the previous target is rejected; the LFSR moves on
        // every cycle, so simply resampling next cycle is enough.
        if (!(prev_vld_q && (w_cand == target_q))) begin
          target_d   = w_cand;
          prev_vld_d = 1'b1;
          win_cnt_d  = w_win_load;
          state_d    = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (sensor_valid_i) begin
          if (sensor_box_i == target_q) begin
            score_d = score_add_sat(score_q, w_diff);
            hit_d   = 1'b1;
          end else begin
            score_d = score_dec_floor(score_q);
            miss_d  = 1'b1;
          end
          gap_cnt_d = GAP_LAST;
          state_d   = ST_GAP;
        end else if (win_cnt_q == '0) begin
          score_d   = score_dec_floor(score_q);
          miss_d    = 1'b1;
          gap_cnt_d = GAP_LAST;
          state_d   = ST_GAP;
        end else begin
          win_cnt_d = win_cnt_q - WIN_CW'(1);
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_PICK;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // End of game overrides the round transition, but a judgement made in
    // the same cycle has already been applied to score/pulses above.
    if (w_active && w_sec_tick) begin
      timer_d = timer_q + TIMER_W'(1);
      if (timer_q == TIMER_LAST) begin
        state_d = ST_OVER;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      timer_q    <= '0;
      target_q   <= '0;
      prev_vld_q <= 1'b0;
      win_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      timer_q    <= timer_d;
      target_q   <= target_d;
      prev_vld_q <= prev_vld_d;
      win_cnt_q  <= win_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
    end
  end

  assign target_box_o   = target_q;
  assign target_valid_o = (state_q == ST_ARMED);
  assign hit_pulse_o    = hit_q;
  assign miss_pulse_o   = miss_q;
  assign score_o        = score_q;
  assign game_timer_o   = timer_q;
  assign difficulty_o   = w_diff;
  assign game_over_o    = (state_q == ST_OVER);

endmodule

`default_nettype wire

// File: tb/tb_game_round_controller.sv
// ============================================================================
// Module  : tb_game_round_controller
// Purpose : Self-checking bench for game_round_controller. A game-rules
//           reference model advances on every clock edge; judged rounds are
//           queued and matched against hit/miss pulses by a monitor, which
//           also compares the visible status every cycle. Instance 1 uses the
//           small timing set; instance 2 plays always-hit rounds long enough
//           to drive the score into saturation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_round_controller;

  localparam int P_IDLE = 0, P_PICK = 1, P_ARMED = 2, P_GAP = 3, P_OVER = 4;

  typedef struct packed {
    int tps; int gs; int w1; int w2; int w3; int gap;
  } cfg_t;

  typedef struct packed {
    int phase; int active; int score; int target;
    int prev_valid; int remaining; int gap_left; int ev;
  } mdl_t;

  localparam cfg_t C1 = '{10, 6, 8, 6, 4, 3};
  localparam cfg_t C2 = '{2000, 3, 4, 4, 4, 1};
  localparam mdl_t MDL_RESET = '{P_IDLE, 0, 0, 0, 0, 0, 0, 0};

  logic clk, reset;
  logic start1, sv1, start2, sv2;
  logic [2:0] lfsr1, lfsr2;
  logic [1:0] sb1, sb2;
  logic [1:0] tb1, tb2, diff1, diff2;
  logic tv1, hit1, miss1, over1, tv2, hit2, miss2, over2;
  logic [10:0] score1, score2;
  logic [5:0] timer1, timer2;

  int checks = 0;
  int failures = 0;
  mdl_t m1 = MDL_RESET;
  mdl_t m2 = MDL_RESET;
  logic [14:0] q1[$];
  logic [14:0] q2[$];

  game_round_controller #(
    .TICKS_PER_SEC(10), .GAME_SECONDS(6), .WIN1(8), .WIN2(6), .WIN3(4), .GAP_CYC(3)
  ) dut1 (
    .clk(clk), .reset(reset), .start_i(start1), .lfsr_value_i(lfsr1),
    .sensor_valid_i(sv1), .sensor_box_i(sb1), .target_box_o(tb1),
    .target_valid_o(tv1), .hit_pulse_o(hit1), .miss_pulse_o(miss1),
    .score_o(score1), .game_timer_o(timer1), .difficulty_o(diff1),
    .game_over_o(over1)
  );

  game_round_controller #(
    .TICKS_PER_SEC(2000), .GAME_SECONDS(3), .WIN1(4), .WIN2(4), .WIN3(4), .GAP_CYC(1)
  ) dut2 (
    .clk(clk), .reset(reset), .start_i(start2), .lfsr_value_i(lfsr2),
    .sensor_valid_i(sv2), .sensor_box_i(sb2), .target_box_o(tb2),
    .target_valid_o(tv2), .hit_pulse_o(hit2), .miss_pulse_o(miss2),
    .score_o(score2), .game_timer_o(timer2), .difficulty_o(diff2),
    .game_over_o(over2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- model
  function automatic int level_of(int t, cfg_t c);
    if (t < c.gs / 3) return 1;
    if (t < (2 * c.gs) / 3) return 2;
    return 3;
  endfunction

  function automatic int win_of(int lvl, cfg_t c);
    if (lvl == 1) return c.w1;
    if (lvl == 2) return c.w2;
    return c.w3;
  endfunction

  function automatic mdl_t step(mdl_t m, cfg_t c, bit st, int lf, bit sv, int sb);
    mdl_t n;
    int lvl;
    n = m;
    n.ev = 0;
    if (m.phase == P_IDLE || m.phase == P_OVER) begin
      if (st) begin
        n.score = 0; n.active = 0; n.prev_valid = 0; n.phase = P_PICK;
      end
      return n;
    end
    lvl = level_of(m.active / c.tps, c);
    case (m.phase)
      P_PICK: begin
        if (!(m.prev_valid != 0 && (lf % 4) == m.target)) begin
          n.target = lf % 4; n.prev_valid = 1;
          n.remaining = win_of(lvl, c); n.phase = P_ARMED;
        end
      end
      P_ARMED: begin
        if (sv) begin
          if (sb == m.target) begin
            n.score = (m.score + lvl > 2047) ? 2047 : m.score + lvl; n.ev = 1;
          end else begin
            n.score = (m.score > 0) ? m.score - 1 : 0; n.ev = 2;
          end
          n.phase = P_GAP; n.gap_left = c.gap;
        end else begin
          n.remaining = m.remaining - 1;
          if (n.remaining == 0) begin
            n.score = (m.score > 0) ? m.score - 1 : 0; n.ev = 2;
            n.phase = P_GAP; n.gap_left = c.gap;
          end
        end
      end
      default: begin
        n.gap_left = m.gap_left - 1;
        if (n.gap_left == 0) n.phase = P_PICK;
      end
    endcase
    n.active = m.active + 1;
    if (n.active / c.tps >= c.gs) n.phase = P_OVER;
    return n;
  endfunction

  function automatic logic [22:0] exp_status(mdl_t m, cfg_t c);
    int t;
    t = m.active / c.tps;
    return {(m.phase == P_ARMED), 2'(m.target), (m.phase == P_OVER), 6'(t),
            2'(level_of(t, c)), 11'(m.score)};
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m1 = MDL_RESET; m2 = MDL_RESET;
        q1.delete(); q2.delete();
      end else begin
        m1 = step(m1, C1, start1, int'(lfsr1), sv1, int'(sb1));
        if (m1.ev != 0) q1.push_back({2'(m1.ev), 11'(m1.score), 2'(m1.target)});
        m2 = step(m2, C2, start2, int'(lfsr2), sv2, int'(sb2));
        if (m2.ev != 0) q2.push_back({2'(m2.ev), 11'(m2.score), 2'(m2.target)});
      end
    end
  end

  // -------------------------------------------------------------- checker
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: status every cycle, pulses matched against the queued judgements
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("status1", 32'({tv1, tb1, over1, timer1, diff1, score1}), 32'(exp_status(m1, C1)));
        if (hit1 || miss1 || q1.size() != 0) begin
          if (q1.size() == 0) check("pulse1_unexpected", 32'({hit1, miss1}), 32'd0);
          else begin
            e = q1.pop_front();
            check("pulse1", 32'({(hit1 ? 2'd1 : 2'd0) | (miss1 ? 2'd2 : 2'd0), score1, tb1}), 32'(e));
          end
        end
        check("status2", 32'({tv2, tb2, over2, timer2, diff2, score2}), 32'(exp_status(m2, C2)));
        if (hit2 || miss2 || q2.size() != 0) begin
          if (q2.size() == 0) check("pulse2_unexpected", 32'({hit2, miss2}), 32'd0);
          else begin
            e = q2.pop_front();
            check("pulse2", 32'({(hit2 ? 2'd1 : 2'd0) | (miss2 ? 2'd2 : 2'd0), score2, tb2}), 32'(e));
          end
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic drive(input int sel, input bit st, input int lf, input bit sv, input int sb);
    start1 = 1'b0; lfsr1 = 3'($urandom % 8); sv1 = 1'b0; sb1 = 2'd0;
    start2 = 1'b0; lfsr2 = 3'($urandom % 8); sv2 = 1'b0; sb2 = 2'd0;
    if (sel == 1) begin
      start1 = st; lfsr1 = 3'(lf); sv1 = sv; sb1 = 2'(sb);
    end else begin
      start2 = st; lfsr2 = 3'(lf); sv2 = sv; sb2 = 2'(sb);
    end
    @(negedge clk);
  endtask

  task automatic run_until1(input int ph, input int lf, input int maxc);
    for (int i = 0; i < maxc && m1.phase != ph; i++)
      drive(1, 1'b0, (lf < 0) ? int'($urandom % 8) : lf, 1'b0, 0);
    if (m1.phase != ph) begin
      checks++; failures++;
      $display("FAIL run_until1 actual=%0d expected=%0d", m1.phase, ph);
    end
  endtask

  task automatic rand_cycle1();
    drive(1, ($urandom % 50) == 0, int'($urandom % 8), ($urandom % 8) == 0,
          ($urandom % 2) ? m1.target : int'($urandom % 4));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start1 = 0; lfsr1 = 0; sv1 = 0; sb1 = 0;
    start2 = 0; lfsr2 = 0; sv2 = 0; sb2 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive(1, 1'b0, 0, 1'b0, 0);

    // first round: lfsr 5 -> box 1, left to time out
    drive(1, 1'b1, 5, 1'b0, 0);
    drive(1, 1'b0, 5, 1'b0, 0);
    check("armed_box1", 32'({tv1, tb1}), 32'({1'b1, 2'd1}));
    run_until1(P_GAP, 5, 40);
    check("timeout_floor", 32'({miss1, score1}), 32'({1'b1, 11'd0}));

    // box 2 armed and hit at difficulty 1
    run_until1(P_ARMED, 2, 20);
    drive(1, 1'b0, 2, 1'b1, 2);
    check("hit_score1", 32'({hit1, score1}), 32'({1'b1, 11'd1}));
    drive(1, 1'b0, 2, 1'b1, 0);            // strike during GAP: ignored
    run_until1(P_PICK, 2, 10);
    repeat (3) drive(1, 1'b0, 2, 1'b0, 0); // repeat candidate held off
    check("pick_resample", 32'(tv1), 32'd0);
    drive(1, 1'b0, 3, 1'b0, 0);
    check("armed_box3", 32'({tv1, tb1}), 32'({1'b1, 2'd3}));
    drive(1, 1'b0, 3, 1'b1, 0);            // wrong box
    check("miss_wrong", 32'({miss1, score1}), 32'({1'b1, 11'd0}));

    // random play to the end of the game
    for (int i = 0; i < 400 && m1.phase != P_OVER; i++) rand_cycle1();
    check("over", 32'({over1, timer1, tv1}), 32'({1'b1, 6'd6, 1'b0}));
    repeat (5) drive(1, 1'b0, int'($urandom % 8), 1'b1, int'($urandom % 4));
    drive(1, 1'b1, int'($urandom % 8), 1'b0, 0);
    check("restart", 32'({over1, score1, timer1}), 32'd0);
    for (int i = 0; i < 20; i++) rand_cycle1();

    // score something, then reset asynchronously in the middle of ARMED
    run_until1(P_ARMED, -1, 30);
    drive(1, 1'b0, int'($urandom % 8), 1'b1, m1.target);
    run_until1(P_ARMED, -1, 30);
    #2 reset = 1'b1;
    #1 check("async_reset", 32'({tv1, tb1, over1, timer1, diff1, score1, hit1, miss1}),
             32'({1'b0, 2'd0, 1'b0, 6'd0, 2'd1, 11'd0, 1'b0, 1'b0}));
    @(negedge clk);
    reset = 1'b0;
    drive(1, 1'b0, 0, 1'b0, 0);

    // instance 2: strike the target every round until the game ends
    drive(2, 1'b1, int'($urandom % 8), 1'b0, 0);
    for (int i = 0; i < 8000 && m2.phase != P_OVER; i++)
      drive(2, 1'b0, int'($urandom % 8), m2.phase == P_ARMED, m2.target);
    check("sat_over", 32'({over2, score2}), 32'({1'b1, 11'd2047}));
    drive(2, 1'b0, 0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/game_round_controller.md
# game_round_controller

Round sequencer for the whack-a-box game. Owns the game FSM: starts a game, draws each target box from the free-running LFSR, opens a difficulty-dependent hit window, judges sensor hits against the target, and updates score, game timer and difficulty. Sits between the LFSR/sensor front end and the display/LED back end. Replaces the ad-hoc per-cycle scoring with one judged event per round.

## Interface
Parameters:
- TICKS_PER_SEC, 50_000_000: clk cycles per game-timer second.
- GAME_SECONDS, 60: game length in seconds; max 63.
- WIN1 / WIN2 / WIN3, 75_000_000 / 50_000_000 / 25_000_000: hit-window length in cycles at difficulty 1/2/3.
- GAP_CYC, 12_500_000: dark cycles between rounds.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  single-cycle start pulse, synchronous.
- lfsr_value  in  3  free-running LFSR output, new value every cycle.
- sensor_valid  in  1  one-cycle strobe, box struck.
- sensor_box  in  2  box struck, qualified by sensor_valid.
- target_box  out  2  current target.
- target_valid  out  1  high while the hit window is open.
- hit_pulse  out  1  one cycle, correct hit judged.
- miss_pulse  out  1  one cycle, wrong box or timeout judged.
- score  out  11  running score.
- game_timer  out  6  elapsed seconds.
- difficulty  out  2  1, 2 or 3 while playing.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, PICK, ARMED, GAP, OVER.
- Reset values: state IDLE; score 0; game_timer 0; difficulty 1; target_box 0; target_valid, hit_pulse, miss_pulse and game_over 0; previous-target flag clear.
- IDLE or OVER, start=1: score 0, game_timer 0, prescaler 0, difficulty 1, previous-target flag cleared, go to PICK. start is ignored in other states.
- PICK: candidate = lfsr_value[1:0].
  - Previous-target flag set and candidate == previous target: stay in PICK and resample next cycle.
  - Otherwise: latch target_box, set previous-target flag, load window counter with WIN{difficulty} − 1, go to ARMED.
- ARMED: target_valid = 1.
  - sensor_valid with sensor_box == target_box: score += difficulty, saturating at 2047; hit_pulse; go to GAP.
  - sensor_valid with any other box: score −1, floor 0; miss_pulse; go to GAP.
  - No sensor_valid and window counter == 0: timeout. score −1, floor 0; miss_pulse; go to GAP.
  - Otherwise decrement the window counter.
- GAP: target_valid 0. Count GAP_CYC cycles, then go to PICK.
- sensor_valid outside ARMED is ignored: no score change, no pulse.
- Game timer: the prescaler runs only in PICK/ARMED/GAP. game_timer increments on prescaler wrap (every TICKS_PER_SEC cycles).
- Difficulty is recomputed from game_timer: 1 if < GAME_SECONDS/3; 2 if < 2·GAME_SECONDS/3; else 3. The window length is sampled only at PICK→ARMED.
- When game_timer reaches GAME_SECONDS, go to OVER from any active state. A sensor event judged in that same cycle is still scored and pulsed. OVER holds score and game_timer, clears target_valid, and sets game_over.
- All arithmetic is unsigned. Score saturation and floor are mandatory; no wrap.

## Timing
- Judgement cycle = the cycle sensor_valid is sampled in ARMED. score, hit_pulse/miss_pulse and the state change are visible after the next clk edge (1-cycle latency). Pulses last exactly 1 cycle.
- A window of WIN cycles: target_valid is high for exactly WIN cycles, and timeout miss_pulse appears on the cycle after the last one.
- PICK lasts ≥1 cycle; a repeat candidate adds 1 cycle per resample.
- Reset mid-game returns every output to its reset value asynchronously. No round resumes.
- start coincident with reset: reset wins.

## Structure
- Shared package `game_pkg`: state encodings, SCORE_MAX = 2047, SCORE_W = 11, BOX_W = 2, difficulty codes.
- One sub-module, `game_tick_gen`: the TICKS_PER_SEC prescaler, with enable and clear and a 1-cycle sec_tick output. Window and gap counters stay in the controller.

## Test plan
Parameters for the bench: TICKS_PER_SEC=10, GAME_SECONDS=6, WIN1/2/3 = 8/6/4, GAP_CYC=3.
- start pulse, lfsr_value=3'b101 → PICK, then ARMED with target_box=1 and target_valid=1 for 8 cycles; timeout gives miss_pulse, score stays 0 (floor).
- Armed on box 2, sensor_valid with box 2 at difficulty 1 → hit_pulse next cycle, score 1, GAP for 3 cycles, then PICK.
- Next PICK with lfsr_value[1:0] equal to the previous target for 3 cycles, then a new value → PICK lasts 4 cycles and target_box is the new value.
- Wrong box at score 1 → miss_pulse, score 0; sensor_valid during GAP → no change.
- Run to game_timer=2 and game_timer=4 → difficulty becomes 2 and then 3, and windows become 6 and 4. At game_timer=6 → OVER, game_over=1, score held; a fresh start clears score to 0.
- Force score to 2046 and hit at difficulty 3 → score 2047 (saturates). Assert reset mid-ARMED → all outputs return to reset values immediately.
